// File: rtl/switch_debouncer.sv
// Push-button debouncer: two-flop synchronizer feeding a counter-qualified FSM that
// produces a clean level plus one-cycle press / release / long-press strobes.
module switch_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES   = 250_000,
    parameter int unsigned LONG_PRESS_CYCLES = 25_000_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sw_i,
    output logic sw_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = (LONG_PRESS_CYCLES == 0) ? 1 : $clog2(LONG_PRESS_CYCLES + 1);
    localparam bit LONG_EN = (LONG_PRESS_CYCLES != 0);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = LONG_EN ? HOLD_W'(LONG_PRESS_CYCLES - 1) : '0;
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic sync1_q, sync2_q;

    state_t            state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              sw_q, sw_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            db_cnt_q  <= '0;
            hold_q    <= '0;
            sw_q      <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            hold_q    <= hold_d;
            sw_q      <= sw_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        hold_d    = hold_q;
        sw_d      = sw_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    sw_d    = 1'b1;
                    press_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = '0;
                end else if (LONG_EN && (hold_q != HOLD_MAX)) begin
                    // Saturating at HOLD_MAX is what keeps long_o to one pulse per press.
                    hold_d = hold_q + HOLD_ONE;
                    long_d = (hold_q == HOLD_LAST);
                end
            end
            RELEASE_WAIT: begin
                // Bouncing back to PRESSED keeps the hold count, so long_o timing survives release bounce.
                if (sync2_q) begin
                    state_d = PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    sw_d      = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sw_o      = sw_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch activity, checked every
// edge against a window-based reference model of the debounced level and strobes.
module tb_switch_debouncer;

    localparam int D  = 4;
    localparam int L  = 10;
    localparam int D0 = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic sw_i;
    logic sw_o, press_o, release_o, long_o;
    logic sw0_o, press0_o, release0_o, long0_o;

    always #5 clk = ~clk;

    switch_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) u_dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .sw_i     (sw_i),
        .sw_o     (sw_o),
        .press_o  (press_o),
        .release_o(release_o),
        .long_o   (long_o)
    );

    switch_debouncer #(.DEBOUNCE_CYCLES(D0), .LONG_PRESS_CYCLES(0)) u_dut0 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .sw_i     (sw_i),
        .sw_o     (sw0_o),
        .press_o  (press0_o),
        .release_o(release0_o),
        .long_o   (long0_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: raw samples per edge since reset, and what the FSM sees two edges later.
    logic raw_a  [0:16383];
    logic seen_a [0:16383];
    int   n;
    logic lvl, lvl0;
    int   hold;
    logic exp_press, exp_release, exp_long, exp_press0, exp_release0;

    // Per-scenario bookkeeping
    int rel, press_at, release_at, long_at, press_cnt, release_cnt, long_cnt, sw_hi_cnt;
    logic v;
    int len;

    function automatic logic seen_at(input int idx);
        return (idx >= 0) ? seen_a[idx] : 1'b0;
    endfunction

    // True when the last len samples seen by the FSM (ending at edge last) all equal val.
    function automatic bit run_of(input int last, input int len_i, input logic val);
        for (int k = 0; k < len_i; k++)
            if (seen_at(last - k) !== val) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        n = 0; lvl = 1'b0; lvl0 = 1'b0; hold = 0;
        exp_press = 1'b0; exp_release = 1'b0; exp_long = 1'b0;
        exp_press0 = 1'b0; exp_release0 = 1'b0;
    endtask

    task automatic model_edge(input logic s);
        raw_a[n]  = s;
        seen_a[n] = (n >= 2) ? raw_a[n-2] : 1'b0;
        exp_press = 1'b0; exp_release = 1'b0; exp_long = 1'b0;
        exp_press0 = 1'b0; exp_release0 = 1'b0;
        // A held press counts a clock only while it stayed high on both this and the prior look.
        if (lvl && seen_at(n - 1) && seen_a[n]) begin
            hold++;
            exp_long = (hold == L);
        end
        if (run_of(n, D + 1, !lvl)) begin
            if (lvl) exp_release = 1'b1;
            else begin exp_press = 1'b1; hold = 0; end
            lvl = !lvl;
        end
        if (run_of(n, D0 + 1, !lvl0)) begin
            if (lvl0) exp_release0 = 1'b1;
            else exp_press0 = 1'b1;
            lvl0 = !lvl0;
        end
        n++;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s edge=%0d got=%b exp=%b", tag, n, obs, exp_v);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs();
        chk("sw_o", sw_o, lvl);
        chk("press_o", press_o, exp_press);
        chk("release_o", release_o, exp_release);
        chk("long_o", long_o, exp_long);
        chk("sw_o_d1", sw0_o, lvl0);
        chk("press_o_d1", press0_o, exp_press0);
        chk("release_o_d1", release0_o, exp_release0);
        chk("long_o_off", long0_o, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sw"}, sw_o, 1'b0);
        chk({tag, "_press"}, press_o, 1'b0);
        chk({tag, "_release"}, release_o, 1'b0);
        chk({tag, "_long"}, long_o, 1'b0);
        chk({tag, "_sw_d1"}, sw0_o, 1'b0);
        chk({tag, "_press_d1"}, press0_o, 1'b0);
    endtask

    task automatic seg_start();
        rel = 0; press_at = -1; release_at = -1; long_at = -1;
        press_cnt = 0; release_cnt = 0; long_cnt = 0; sw_hi_cnt = 0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input logic s);
        sw_i = s;
        @(posedge clk);
        model_edge(s);
        #1;
        check_outputs();
        if (press_o)   begin press_at = rel;   press_cnt++;   end
        if (release_o) begin release_at = rel; release_cnt++; end
        if (long_o)    begin long_at = rel;    long_cnt++;    end
        if (sw_o) sw_hi_cnt++;
        rel++;
        @(negedge clk);
    endtask

    task automatic reset_cycles(input int k);
        rst_n = 1'b0;
        #1;
        check_zero("rst_now");
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        sw_i  = 1'b0;
        model_reset();
        seg_start();
        #2;
        reset_cycles(3);

        // Clean press held long enough for a long press
        seg_start();
        for (int i = 0; i < 40; i++) tick(1'b1);
        $display("clean/long press: press_at=%0d long_at=%0d longs=%0d", press_at, long_at, long_cnt);
        chk_int("clean_press_edge", press_at, D + 2);
        chk_int("clean_press_cnt", press_cnt, 1);
        chk_int("clean_long_edge", long_at, D + 2 + L);
        chk_int("clean_long_cnt", long_cnt, 1);
        chk_int("clean_release_cnt", release_cnt, 0);

        // Release with bounce 0,0,1 then hold 0; final zero run starts at rel 3
        seg_start();
        tick(1'b0); tick(1'b0); tick(1'b1);
        for (int i = 0; i < 12; i++) tick(1'b0);
        $display("release bounce: release_at=%0d releases=%0d", release_at, release_cnt);
        chk_int("rel_bounce_edge", release_at, 3 + D + 2);
        chk_int("rel_bounce_cnt", release_cnt, 1);
        chk_int("rel_bounce_long", long_cnt, 0);
        chk_int("rel_bounce_sw_hi", sw_hi_cnt, 3 + D + 2);

        // Hold counter freezes across a release bounce and resumes
        seg_start();
        for (int i = 0; i < 10; i++) tick(1'b1);
        tick(1'b0); tick(1'b0);
        for (int i = 0; i < 12; i++) tick(1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0);
        $display("hold resume: press_at=%0d long_at=%0d release_at=%0d", press_at, long_at, release_at);
        chk_int("resume_press_edge", press_at, 6);
        chk_int("resume_long_edge", long_at, 19);
        chk_int("resume_long_cnt", long_cnt, 1);
        chk_int("resume_release_edge", release_at, 24 + D + 2);

        // Bounce rejection: 1,1,0,1,1,1,0 then hold 0
        seg_start();
        tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b1); tick(1'b1);
        for (int i = 0; i < 11; i++) tick(1'b0);
        $display("bounce reject: presses=%0d releases=%0d sw_hi=%0d", press_cnt, release_cnt, sw_hi_cnt);
        chk_int("bounce_press_cnt", press_cnt, 0);
        chk_int("bounce_release_cnt", release_cnt, 0);
        chk_int("bounce_sw_hi", sw_hi_cnt, 0);

        // Reset while the press pulse is high and the switch is held
        seg_start();
        for (int i = 0; i < D + 3; i++) tick(1'b1);
        chk("pre_reset_press", press_o, 1'b1);
        reset_cycles(2);
        seg_start();
        for (int i = 0; i < 12; i++) tick(1'b1);
        $display("reset held: press_at=%0d", press_at);
        chk_int("reset_held_press_edge", press_at, D + 2);
        chk_int("reset_held_press_cnt", press_cnt, 1);
        for (int i = 0; i < 10; i++) tick(1'b0);

        // Random bursts: short ones act as bounce, long ones qualify
        for (int b = 0; b < 300; b++) begin
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 30)) : int'($urandom_range(1, 5));
            if (b == 150) reset_cycles(2);
            seg_start();
            for (int j = 0; j < len; j++) tick(v);
            $display("burst %0d: sw_i=%b len=%0d sw_o=%b", b, v, len, sw_o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
